fifo_wconv: RTL and testbench

Parametrised width-converting FIFO (controller plus storage).
- Each accepted write carries RATIO narrow words packed into one wide word.
- Reads pop one narrow word per cycle.
- Generalises the 2:1 split-address controller to any RATIO, adds occupancy count, programmable almost-full/almost-empty flags and overflow/underflow pulses.
- Sits between a wide producer (e.g. a 2x/4x sample packer) and a narrow consumer stream.

---
 rtl/fifo_wconv_pkg.sv | 21 ++
 rtl/fifo_wconv_ctrl.sv | 79 +++++++
 rtl/fifo_wconv.sv | 77 +++++++
 tb/tb_fifo_wconv.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_wconv_pkg.sv
// rtl/fifo_wconv_pkg.sv - shared helpers for the width-converting FIFO
package fifo_wconv_pkg;

   // Widest write word the slice helper can carry (RATIO*DATA_WIDTH must fit)
   localparam int PKG_MAX_BITS = 1024;

   // Returns narrow slice idx of a wide word in the low bits; caller truncates to width
   function automatic logic [PKG_MAX_BITS-1:0] wide_slice(
      input logic [PKG_MAX_BITS-1:0] wide,
      input int unsigned             idx,
      input int unsigned             width
   );
      return wide >> (idx * width);
   endfunction

   // A write must pack a power-of-two number of words that fits in the storage
   function automatic bit ratio_ok(input int ratio, input int depth);
      return (ratio >= 1) && (ratio <= depth) && ((ratio & (ratio - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_wconv_ctrl.sv
// rtl/fifo_wconv_ctrl.sv - pointers, occupancy count, accept logic and flags
module fifo_wconv_ctrl
   import fifo_wconv_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int RATIO      = 2,
   parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic                  rd,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  wr_ready,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   // One extra bit over count so free-slot sums and the next count never wrap
   localparam int CW    = ADDR_WIDTH + 2;

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]         cnt_ext;
   logic [CW-1:0]         free_slots;
   logic [CW-1:0]         count_next;
   logic                  rd_acc;
   logic                  wr_acc;

   // Accept decisions: a same-cycle read frees a slot the write may use
   always_comb begin
      cnt_ext    = {1'b0, count};
      free_slots = CW'(DEPTH) - cnt_ext;
      rd_acc     = rd && (count != '0);
      wr_acc     = wr && ((free_slots + CW'(rd_acc)) >= CW'(RATIO));
      count_next = cnt_ext + (wr_acc ? CW'(RATIO) : '0) - CW'(rd_acc);
   end

   // Pointers, count and all flags advance together so flags always match count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         wr_ready     <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(RATIO);
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         count        <= count_next[ADDR_WIDTH:0];
         empty        <= (count_next == '0);
         full         <= (count_next == CW'(DEPTH));
         wr_ready     <= ((CW'(DEPTH) - count_next) >= CW'(RATIO));
         almost_full  <= (count_next >= CW'(AF_LEVEL));
         almost_empty <= (count_next <= CW'(AE_LEVEL));
         overflow     <= wr && !wr_acc;
         underflow    <= rd && (count == '0);
      end
   end

   assign w_addr = wr_ptr;
   assign r_addr = rd_ptr;
   assign wr_en  = wr_acc;

endmodule

// File: rtl/fifo_wconv.sv
// rtl/fifo_wconv.sv - wide-write, narrow-read FIFO with storage and write demux
module fifo_wconv
   import fifo_wconv_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int RATIO      = 2,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_LEVEL   = (2**ADDR_WIDTH) - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr,
   input  logic [RATIO*DATA_WIDTH-1:0] w_data,
   input  logic                        rd,
   output logic [DATA_WIDTH-1:0]       r_data,
   output logic                        empty,
   output logic                        full,
   output logic                        wr_ready,
   output logic                        almost_full,
   output logic                        almost_empty,
   output logic [ADDR_WIDTH:0]         count,
   output logic                        overflow,
   output logic                        underflow
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   if (!ratio_ok(RATIO, DEPTH)) begin : g_bad_ratio
      $error("fifo_wconv: RATIO must be a power of two between 1 and DEPTH");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] slices [RATIO];
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  wr_en;

   fifo_wconv_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RATIO      (RATIO),
      .AF_LEVEL   (AF_LEVEL),
      .AE_LEVEL   (AE_LEVEL)
   ) u_ctrl (
      .clk          (clk),
      .reset        (reset),
      .wr           (wr),
      .rd           (rd),
      .w_addr       (w_addr),
      .wr_en        (wr_en),
      .r_addr       (r_addr),
      .count        (count),
      .empty        (empty),
      .full         (full),
      .wr_ready     (wr_ready),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   for (genvar g = 0; g < RATIO; g++) begin : g_slice
      assign slices[g] = DATA_WIDTH'(wide_slice(PKG_MAX_BITS'(w_data), g, DATA_WIDTH));
   end

   // Scatter the wide word into RATIO consecutive slots, LSB slice first; storage is never reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < RATIO; i++) begin
            mem[w_addr + ADDR_WIDTH'(i)] <= slices[i];
         end
      end
   end

   assign r_data = mem[r_addr];

endmodule

// File: tb/tb_fifo_wconv.sv
// tb/tb_fifo_wconv.sv - self-checking bench for fifo_wconv against a queue model
module tb_fifo_wconv;

   localparam int DW    = 8;
   localparam int RATIO = 2;
   localparam int AW    = 3;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr;
   logic          rd;
   logic [15:0]   w_data;
   logic [DW-1:0] r_data;
   logic          empty;
   logic          full;
   logic          wr_ready;
   logic          almost_full;
   logic          almost_empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   int  passed = 0;
   int  total  = 0;
   byte unsigned q[$];
   bit  exp_ovf;
   bit  exp_unf;

   fifo_wconv #(
      .DATA_WIDTH (DW),
      .RATIO      (RATIO),
      .ADDR_WIDTH (AW),
      .AF_LEVEL   (AF),
      .AE_LEVEL   (AE)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr           (wr),
      .w_data       (w_data),
      .rd           (rd),
      .r_data       (r_data),
      .empty        (empty),
      .full         (full),
      .wr_ready     (wr_ready),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Every output is derived from the model queue's size and head
   task automatic check_state(input string tag);
      int sz;
      sz = q.size();
      chk({tag, ".count"},        32'(count),        32'(sz));
      chk({tag, ".empty"},        32'(empty),        32'(sz == 0));
      chk({tag, ".full"},         32'(full),         32'(sz == DEPTH));
      chk({tag, ".wr_ready"},     32'(wr_ready),     32'(DEPTH - sz >= RATIO));
      chk({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AF));
      chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
      chk({tag, ".overflow"},     32'(overflow),     32'(exp_ovf));
      chk({tag, ".underflow"},    32'(underflow),    32'(exp_unf));
      if (sz > 0) chk({tag, ".r_data"}, 32'(r_data), 32'(q[0]));
   endtask

   // Called at a negedge: drive, let one posedge happen, update model, check at next negedge
   task automatic step(input string tag, input bit w, input logic [15:0] d, input bit r);
      int  sz;
      bit  rd_acc;
      bit  wr_acc;
      sz     = q.size();
      wr     = w;
      w_data = d;
      rd     = r;
      rd_acc = r && (sz > 0);
      wr_acc = w && ((DEPTH - sz + int'(rd_acc)) >= RATIO);
      exp_unf = r && (sz == 0);
      exp_ovf = w && !wr_acc;
      @(posedge clk);
      if (rd_acc) void'(q.pop_front());
      if (wr_acc) begin
         q.push_back(d[7:0]);
         q.push_back(d[15:8]);
      end
      @(negedge clk);
      wr = 1'b0;
      rd = 1'b0;
      check_state(tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      wr    = 1'b0;
      rd    = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      check_state(tag);
   endtask

   initial begin
      reset  = 1'b1;
      wr     = 1'b0;
      rd     = 1'b0;
      w_data = '0;

      // 1: single wide write then two narrow reads
      do_reset("t1.rst");
      step("t1.wr", 1'b1, 16'hBBAA, 1'b0);
      chk("t1.r_data_aa", 32'(r_data), 32'h0000_00AA);
      step("t1.rd0", 1'b0, 16'h0, 1'b1);
      chk("t1.r_data_bb", 32'(r_data), 32'h0000_00BB);
      step("t1.rd1", 1'b0, 16'h0, 1'b1);
      chk("t1.empty_after", 32'(empty), 32'd1);

      // 2: fill to full, then an extra write overflows
      step("t2.w0", 1'b1, 16'h0100, 1'b0);
      step("t2.w1", 1'b1, 16'h0302, 1'b0);
      step("t2.w2", 1'b1, 16'h0504, 1'b0);
      step("t2.w3", 1'b1, 16'h0706, 1'b0);
      chk("t2.full", 32'(full), 32'd1);
      step("t2.w4", 1'b1, 16'h0908, 1'b0);
      chk("t2.ovf", 32'(overflow), 32'd1);
      step("t2.idle", 1'b0, 16'h0, 1'b0);

      // 3: count 7, lone write rejected, write with read accepted, then drain
      do_reset("t3.rst");
      step("t3.w0", 1'b1, 16'h1110, 1'b0);
      step("t3.w1", 1'b1, 16'h1312, 1'b0);
      step("t3.w2", 1'b1, 16'h1514, 1'b0);
      step("t3.w3", 1'b1, 16'h1716, 1'b0);
      step("t3.r0", 1'b0, 16'h0, 1'b1);
      step("t3.wlone", 1'b1, 16'h1918, 1'b0);
      step("t3.wrd", 1'b1, 16'h1918, 1'b1);
      chk("t3.count8", 32'(count), 32'd8);
      for (int i = 0; i < 8; i++) step("t3.drain", 1'b0, 16'h0, 1'b1);

      // 4: interleaved write+read pairs across pointer wrap
      do_reset("t4.rst");
      for (int i = 0; i < 20; i++) step("t4.pair", 1'b1, 16'($urandom), 1'b1);
      for (int i = 0; i < 10; i++) step("t4.drain", 1'b0, 16'h0, 1'b1);

      // 5: read on empty underflows; read+write on empty accepts only the write
      do_reset("t5.rst");
      step("t5.rd_empty", 1'b0, 16'h0, 1'b1);
      step("t5.idle", 1'b0, 16'h0, 1'b0);
      step("t5.rdwr", 1'b1, 16'h5A4B, 1'b1);
      chk("t5.count2", 32'(count), 32'd2);

      // 6: asynchronous reset with count 5, then write lands at slot 0
      do_reset("t6.rst");
      step("t6.w0", 1'b1, 16'h3130, 1'b0);
      step("t6.w1", 1'b1, 16'h3332, 1'b0);
      step("t6.w2", 1'b1, 16'h3534, 1'b0);
      step("t6.r0", 1'b0, 16'h0, 1'b1);
      chk("t6.count5", 32'(count), 32'd5);
      #2 reset = 1'b1;
      #1;
      q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      check_state("t6.async");
      @(negedge clk);
      reset = 1'b0;
      step("t6.wafter", 1'b1, 16'h2211, 1'b0);
      chk("t6.slot0", 32'(r_data), 32'h0000_0011);
      step("t6.rafter", 1'b0, 16'h0, 1'b1);

      // Random traffic against the model
      do_reset("rnd.rst");
      for (int i = 0; i < 400; i++) begin
         step("rnd", 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
